div_seq: RTL and testbench

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; the inverse companion of the single-cycle multiplier.
- Produces quotient (LO) and remainder (HI) for a 32-bit dividend/divisor pair.
- Sits beside the multiplier in the EX stage. The pipeline stalls on busy and captures q/r into HI/LO on done.
- flush aborts an in-flight operation on exception or branch squash.

---
 rtl/div_if.sv | 25 ++
 rtl/div_seq.sv | 130 +++++++++++++
 tb/tb_div_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and result bundle between the EX-stage control and the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU. Works on operand magnitudes for
// WIDTH iterations, then applies signs: quotient truncates toward zero and
// the remainder takes the dividend's sign. Divide-by-zero returns all-ones
// quotient and the original dividend as remainder, with the same latency.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Partial remainder is always below |b|, so WIDTH bits of storage suffice;
  // the WIDTH+1-bit form only exists transiently in p_shift/trial.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] orig_a;
  logic             neg_q, neg_r, dbz;

  logic [WIDTH-1:0] q_reg, r_reg;
  logic             dbz_reg;

  logic             accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_shift, trial;
  logic [WIDTH-1:0] p_nxt, dvd_nxt;
  logic [WIDTH-1:0] q_res, r_res;

  // A new operation can start whenever no iteration is in flight; flush wins.
  assign accept = (state != CALC) && bus.start && !bus.flush;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        bus.busy = 1'b1;
        if (bus.flush)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = accept ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step plus the sign-corrected result of the final step.
  always_comb begin
    p_shift = {p, dvd[WIDTH-1]};
    trial   = p_shift - {1'b0, mag_b};
    if (trial[WIDTH]) begin
      p_nxt   = p_shift[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
    end else begin
      p_nxt   = trial[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
    end
    q_res = dbz ? '1     : (neg_q ? -dvd_nxt : dvd_nxt);
    r_res = dbz ? orig_a : (neg_r ? -p_nxt   : p_nxt);
  end

  // Operand capture, iteration, and result registers.
  // NOTE: all datapath registers are small flops (no memory), so they are
  // all cleared by reset for a deterministic post-reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      p       <= '0;
      dvd     <= '0;
      mag_b   <= '0;
      orig_a  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz     <= 1'b0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      p      <= '0;
      dvd    <= a_mag;
      mag_b  <= b_mag;
      orig_a <= bus.a;
      neg_q  <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r  <= bus.is_signed & bus.a[WIDTH-1];
      dbz    <= (bus.b == '0);
    end else if (state == CALC && !bus.flush) begin
      p   <= p_nxt;
      dvd <= dvd_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        q_reg   <= q_res;
        r_reg   <= r_res;
        dbz_reg <= dbz;
      end
    end
  end

  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases with literal expectations
// plus randomized traffic checked every cycle against a timing/arithmetic model.
module tb_div_seq;

  localparam int WIDTH = 32;
  localparam int LAT   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer division on 64-bit signed values.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Behavioural model: an accepted op completes LAT edges later unless
  // flushed or reset; results held until the next completion.
  logic        m_pending = 1'b0;
  int          m_left    = 0;
  logic        m_done    = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  logic        m_z = 1'b0;
  logic [31:0] p_q, p_r;
  logic        p_z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 1'b0; m_left = 0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pending) begin
        if (bus.flush) m_pending = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_pending = 1'b0;
            m_done    = 1'b1;
            m_q = p_q; m_r = p_r; m_z = p_z;
          end
        end
      end else if (bus.start && !bus.flush) begin
        m_pending = 1'b1;
        m_left    = LAT;
        ref_div(bus.is_signed, bus.a, bus.b, p_q, p_r, p_z);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_pending));
    check("done", 32'(bus.done), 32'(m_done));
    check("q", bus.q, m_q);
    check("r", bus.r, m_r);
    check("div_by_zero", 32'(bus.div_by_zero), 32'(m_z));
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.is_signed = s; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom);
  endtask

  // Counts edges until done is seen; bounded.
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    forever begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) nbusy++;
      if (n >= LAT + 8) begin
        check("done_timeout", 32'(n), 32'(LAT));
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic expect_result(input string name, input logic [31:0] eq, input logic [31:0] er,
                               input logic ez);
    check({name, "_q"}, bus.q, eq);
    check({name, "_r"}, bus.r, er);
    check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  task automatic directed(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
    int n, nb;
    issue(s, a, b);
    wait_done(n, nb);
    check({name, "_latency"}, 32'(n), 32'(LAT));
    expect_result(name, eq, er, ez);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] tq, tr;
    logic        tz;
    int          n, nb, dones;

    bus.start = 1'b0; bus.flush = 1'b0; bus.is_signed = 1'b0;
    bus.a = '0; bus.b = '0;

    // Pin the reference model to hand-computed values.
    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, tq, tr, tz);
    check("model_neg7_div2_q", tq, 32'hFFFF_FFFD);
    check("model_neg7_div2_r", tr, 32'hFFFF_FFFF);
    ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, tq, tr, tz);
    check("model_ovf_q", tq, 32'h8000_0000);
    check("model_ovf_r", tr, 32'h0);
    ref_div(1'b1, 32'hFFFF_FFFB, 32'h0, tq, tr, tz);
    check("model_dbz_q", tq, 32'hFFFF_FFFF);
    check("model_dbz_r", tr, 32'hFFFF_FFFB);

    #12;
    expect_result("reset", 32'h0, 32'h0, 1'b0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 32'd100, 32'd7);
    wait_done(n, nb);
    check("divu_latency", 32'(n), 32'(LAT));
    check("divu_busy_cycles", 32'(nb), 32'(LAT));
    expect_result("divu", 32'd14, 32'd2, 1'b0);
    @(posedge clk); #1;

    directed("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    directed("div_7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    directed("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
    directed("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    directed("div_by_zero", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // Back-to-back: start asserted during the DONE cycle.
    issue(1'b0, 32'd100, 32'd7);
    wait_done(n, nb);
    expect_result("b2b_first", 32'd14, 32'd2, 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, nb);
    check("b2b_latency", 32'(n), 32'(LAT));
    expect_result("b2b_second", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;

    // start pulsed mid-CALC is ignored.
    issue(1'b0, 32'd1000, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd4);
    wait_done(n, nb);
    check("calc_start_latency", 32'(n), 32'(LAT - 6));
    expect_result("calc_start", 32'd100, 32'd0, 1'b0);
    @(posedge clk); #1;

    // flush mid-CALC: no done, results retained.
    issue(1'b0, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'h0);
    expect_result("flush_hold", 32'd100, 32'd0, 1'b0);
    dones = 0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'h0);

    // flush and start together: nothing accepted.
    @(posedge clk); #1; bus.flush = 1'b1;
    issue(1'b1, 32'd20, 32'd3);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 32'(bus.busy), 32'h0);

    // Reset mid-CALC clears everything immediately.
    @(posedge clk); #1;
    issue(1'b0, 32'd77, 32'd5);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    expect_result("rst_mid", 32'h0, 32'h0, 1'b0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      bus.start     = ($urandom % 3 == 0);
      bus.flush     = ($urandom % 60 == 0);
      bus.is_signed = 1'($urandom);
      bus.a         = pick();
      bus.b         = pick();
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
